// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: three-channel PWM driver for the active-low RGB LED pins.
// Duty sets arrive over a valid/ready handshake into a single pending buffer
// and are promoted to the active set only when the PWM counter wraps, so a
// running period is never glitched.
module rgb_pwm_driver #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 47
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                color_valid,
    output logic                color_ready,
    input  logic [PWM_BITS-1:0] r_duty,
    input  logic [PWM_BITS-1:0] g_duty,
    input  logic [PWM_BITS-1:0] b_duty,
    output logic                RGB_R,
    output logic                RGB_G,
    output logic                RGB_B,
    output logic                period_start
);

    // A prescaler of 1 still needs a one-bit counter that simply stays at 0.
    localparam int                 PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]   PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [PWM_BITS-1:0] r;
        logic [PWM_BITS-1:0] g;
        logic [PWM_BITS-1:0] b;
    } duty_set_t;

    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic                boundary;
    logic                transfer;
    duty_set_t           pending;
    duty_set_t           active;
    logic                pending_full;

    assign tick        = (pre_cnt == PRE_MAX);
    assign boundary    = tick && (pwm_cnt == CNT_MAX);
    assign color_ready = ~pending_full;
    assign transfer    = color_valid && color_ready;

    // Prescaler: divide clk down to one PWM tick every PRESCALE cycles.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use <= so every flop samples pre-edge values.
        if (rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // PWM counter: advances once per tick and wraps naturally at its width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Pending buffer: accept a duty set when empty, drain it at the boundary.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the buffer contents are reset with the flag so a reset drops any queued colour.
        if (rst) begin
            pending      <= '0;
            pending_full <= 1'b0;
        end else if (transfer) begin
            // A transfer needs an empty buffer, so it can never collide with a
            // drain; on a boundary the new data waits for the following wrap.
            pending      <= '{r: r_duty, g: g_duty, b: b_duty};
            pending_full <= 1'b1;
        end else if (boundary) begin
            pending_full <= 1'b0;
        end
    end

    // Active set: swapped only on the wrap edge, and only if something is queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= '0;
        end else if (boundary && pending_full) begin
            active <= pending;
        end
    end

    // Output stage: registered compare and period marker, pins idle high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RGB_R        <= 1'b1;
            RGB_G        <= 1'b1;
            RGB_B        <= 1'b1;
            period_start <= 1'b0;
        end else begin
            RGB_R        <= ~(pwm_cnt < active.r);
            RGB_G        <= ~(pwm_cnt < active.g);
            RGB_B        <= ~(pwm_cnt < active.b);
            period_start <= boundary;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: two driver instances (PRESCALE=1 and PRESCALE=47) share
// clock, reset and upstream inputs. A time-based model predicts ready, pins and
// period_start for both every cycle; directed phases add literal expectations.
module tb_rgb_pwm_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       color_valid;
    logic [7:0] r_duty, g_duty, b_duty;
    logic [1:0] rdy, ps, pin_r, pin_g, pin_b;

    int compared   = 0;
    int mismatched = 0;

    // Model state per instance: k = clk edges since reset release.
    int kk    [2];
    int act   [2][3];
    int pend  [2][3];
    bit pfull [2];
    bit e_pin [2][3];
    bit e_ps  [2];

    rgb_pwm_driver #(.PWM_BITS(8), .PRESCALE(1)) dut_fast (
        .clk(clk), .rst(rst), .color_valid(color_valid), .color_ready(rdy[0]),
        .r_duty(r_duty), .g_duty(g_duty), .b_duty(b_duty),
        .RGB_R(pin_r[0]), .RGB_G(pin_g[0]), .RGB_B(pin_b[0]), .period_start(ps[0])
    );

    rgb_pwm_driver #(.PWM_BITS(8), .PRESCALE(47)) dut_slow (
        .clk(clk), .rst(rst), .color_valid(color_valid), .color_ready(rdy[1]),
        .r_duty(r_duty), .g_duty(g_duty), .b_duty(b_duty),
        .RGB_R(pin_r[1]), .RGB_G(pin_g[1]), .RGB_B(pin_b[1]), .period_start(ps[1])
    );

    // 10-time-unit clock; inputs change and outputs are sampled on the falling edge.
    always #5 clk = ~clk;

    function automatic int pres(input int i);
        return (i == 0) ? 1 : 47;
    endfunction

    function automatic int pin(input int i, input int c);
        case (c)
            0:       return int'(pin_r[i]);
            1:       return int'(pin_g[i]);
            default: return int'(pin_b[i]);
        endcase
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            kk[i]    = 0;
            pfull[i] = 1'b0;
            e_ps[i]  = 1'b0;
            for (int c = 0; c < 3; c++) begin
                act[i][c]   = 0;
                pend[i][c]  = 0;
                e_pin[i][c] = 1'b1;
            end
        end
    endtask

    // Predict the effect of the coming rising edge from elapsed time alone.
    task automatic model_edge();
        int  d[3];
        int  period, cnt;
        bit  bnd, xfer;
        if (rst) begin
            model_reset();
            return;
        end
        d[0] = int'(r_duty);
        d[1] = int'(g_duty);
        d[2] = int'(b_duty);
        for (int i = 0; i < 2; i++) begin
            period = 256 * pres(i);
            cnt    = (kk[i] / pres(i)) % 256;
            bnd    = (kk[i] % period) == (period - 1);
            for (int c = 0; c < 3; c++) e_pin[i][c] = !(cnt < act[i][c]);
            e_ps[i] = bnd;
            xfer    = color_valid && !pfull[i];
            if (bnd && pfull[i]) begin
                for (int c = 0; c < 3; c++) act[i][c] = pend[i][c];
                pfull[i] = 1'b0;
            end
            if (xfer) begin
                for (int c = 0; c < 3; c++) pend[i][c] = d[c];
                pfull[i] = 1'b1;
            end
            kk[i]++;
        end
    endtask

    task automatic compare_all();
        string nm[3];
        nm[0] = "RGB_R"; nm[1] = "RGB_G"; nm[2] = "RGB_B";
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d color_ready k=%0d", i, kk[i]), int'(rdy[i]), int'(!pfull[i]));
            check($sformatf("u%0d period_start k=%0d", i, kk[i]), int'(ps[i]), int'(e_ps[i]));
            for (int c = 0; c < 3; c++)
                check($sformatf("u%0d %s k=%0d", i, nm[c], kk[i]), pin(i, c), int'(e_pin[i][c]));
        end
    endtask

    // One clock: compare now, predict the edge, then land on the next falling edge.
    task automatic step();
        compare_all();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int s = 0; s < n; s++) step();
    endtask

    task automatic wait_ps(input int i, input int bound);
        int n = 0;
        while (ps[i] !== 1'b1 && n < bound) begin
            step();
            n++;
        end
        check($sformatf("u%0d wait period_start", i), int'(ps[i]), 1);
    endtask

    task automatic wait_ready(input int i, input int bound);
        int n = 0;
        while (rdy[i] !== 1'b1 && n < bound) begin
            step();
            n++;
        end
        check($sformatf("u%0d wait color_ready", i), int'(rdy[i]), 1);
    endtask

    // Count lit (low) samples per pin over n cycles starting now.
    task automatic count_lows(input int i, input int n, output int lr, output int lg, output int lb);
        lr = 0; lg = 0; lb = 0;
        for (int s = 0; s < n; s++) begin
            lr += (pin_r[i] == 1'b0) ? 1 : 0;
            lg += (pin_g[i] == 1'b0) ? 1 : 0;
            lb += (pin_b[i] == 1'b0) ? 1 : 0;
            step();
        end
    endtask

    task automatic send_one(input int r, input int g, input int b);
        r_duty      = 8'(r);
        g_duty      = 8'(g);
        b_duty      = 8'(b);
        color_valid = 1'b1;
        step();
        color_valid = 1'b0;
    endtask

    function automatic logic [7:0] rand_duty();
        case ($urandom_range(0, 3))
            0:       return 8'd0;
            1:       return 8'd255;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        int lr, lg, lb;

        rst         = 1'b1;
        color_valid = 1'b0;
        r_duty      = '0;
        g_duty      = '0;
        b_duty      = '0;
        model_reset();
        @(negedge clk);

        // Reset state of both instances.
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d reset color_ready", i), int'(rdy[i]), 1);
            check($sformatf("u%0d reset RGB_R", i), int'(pin_r[i]), 1);
            check($sformatf("u%0d reset period_start", i), int'(ps[i]), 0);
        end
        steps(2);
        rst = 1'b0;

        // Mid-period reset with a queued set: load 200s, queue 50s, then reset.
        check("u0 ready before first send", int'(rdy[0]), 1);
        send_one(200, 200, 200);
        while (kk[0] < 300) step();
        send_one(50, 50, 50);
        steps(20);
        check("u0 RGB_R lit before reset", int'(pin_r[0]), 0);
        check("u0 pending full before reset", int'(rdy[0]), 0);
        rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d async reset RGB_R", i), int'(pin_r[i]), 1);
            check($sformatf("u%0d async reset RGB_G", i), int'(pin_g[i]), 1);
            check($sformatf("u%0d async reset RGB_B", i), int'(pin_b[i]), 1);
            check($sformatf("u%0d async reset period_start", i), int'(ps[i]), 0);
            check($sformatf("u%0d async reset color_ready", i), int'(rdy[i]), 1);
        end
        steps(3);
        rst = 1'b0;
        count_lows(0, 600, lr, lg, lb);
        check("u0 pins stay off after reset (R)", lr, 0);
        check("u0 pins stay off after reset (G)", lg, 0);

        // Duty accuracy over two full periods.
        send_one(64, 128, 0);
        wait_ps(0, 300);
        for (int p = 0; p < 2; p++) begin
            count_lows(0, 256, lr, lg, lb);
            check($sformatf("u0 R lit per period #%0d", p), lr, 64);
            check($sformatf("u0 G lit per period #%0d", p), lg, 128);
            check($sformatf("u0 B lit per period #%0d", p), lb, 0);
            check($sformatf("u0 period_start spacing 256 #%0d", p), int'(ps[0]), 1);
        end

        // Boundary alignment: R=255 sent mid-period.
        steps(100);
        send_one(255, 128, 0);
        wait_ps(0, 300);
        check("u0 RGB_R off on period_start cycle", int'(pin_r[0]), 1);
        step();
        check("u0 RGB_R lit one clk after period_start", int'(pin_r[0]), 0);
        count_lows(0, 255, lr, lg, lb);
        check("u0 R=255 lit cycles", lr, 255);
        check("u0 period_start after R=255 period", int'(ps[0]), 1);

        // Backpressure: second set stalls until the cycle after the boundary.
        steps(20);
        check("u0 ready before first of pair", int'(rdy[0]), 1);
        send_one(1, 2, 3);
        r_duty = 8'd4; g_duty = 8'd5; b_duty = 8'd6;
        color_valid = 1'b1;
        check("u0 stalled second transfer", int'(rdy[0]), 0);
        wait_ready(0, 300);
        check("u0 ready rises with period_start", int'(ps[0]), 1);
        step();
        color_valid = 1'b0;
        check("u0 second set now pending", int'(rdy[0]), 0);
        count_lows(0, 255, lr, lg, lb);
        check("u0 first set active (R)", lr, 1);
        check("u0 first set active (B)", lb, 3);
        count_lows(0, 256, lr, lg, lb);
        check("u0 second set active (R)", lr, 4);
        check("u0 second set active (G)", lg, 5);

        // Transfer on the exact boundary edge goes to pending, no bypass.
        begin
            int n = 0;
            while (kk[0] % 256 != 255 && n < 300) begin
                step();
                n++;
            end
        end
        check("u0 ready on boundary cycle", int'(rdy[0]), 1);
        send_one(100, 50, 25);
        check("u0 period_start on simultaneous edge", int'(ps[0]), 1);
        check("u0 simultaneous set held pending", int'(rdy[0]), 0);
        count_lows(0, 256, lr, lg, lb);
        check("u0 old duty kept after simultaneous (R)", lr, 4);
        count_lows(0, 256, lr, lg, lb);
        check("u0 new duty next period (R)", lr, 100);
        check("u0 new duty next period (B)", lb, 25);

        // Randomized traffic; data held stable while the fast instance stalls.
        for (int n = 0; n < 3000; n++) begin
            if (!(color_valid && pfull[0])) begin
                color_valid = ($urandom_range(0, 5) == 0);
                if (color_valid) begin
                    r_duty = rand_duty();
                    g_duty = rand_duty();
                    b_duty = rand_duty();
                end
            end
            step();
        end
        color_valid = 1'b0;

        // Prescaler 47: R=1 lights 47 clk per 12032-clk period.
        r_duty = 8'd1; g_duty = 8'd0; b_duty = 8'd0;
        color_valid = 1'b1;
        wait_ready(1, 13000);
        step();
        color_valid = 1'b0;
        wait_ps(1, 13000);
        count_lows(1, 12032, lr, lg, lb);
        check("u1 R=1 lit clk per period", lr, 47);
        check("u1 G=0 lit clk per period", lg, 0);
        check("u1 period_start spacing 12032", int'(ps[1]), 1);
        steps(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
- Downstream stage of the RGB colour sequencer: takes per-channel 8-bit duty values over a valid/ready handshake and drives the three active-low RGB LED pins with PWM, so colours can blend instead of being plain on/off.
- New duty sets are double-buffered and take effect only at a PWM period boundary, so a period is never glitched.
- Runs on the 12 MHz board clock.

Parameters:
- PWM_BITS, 8, width of the duty values and the PWM counter; one period = 2^PWM_BITS ticks.
- PRESCALE, 47, clk cycles per PWM tick (≥1); the default gives 12e6/(47·256) ≈ 997 Hz.

Ports:
- clk  input  1  12 MHz system clock.
- rst  input  1  asynchronous, active-high reset.
- color_valid  input  1  upstream presents a duty set.
- color_ready  output  1  pending buffer empty; a transfer occurs when color_valid && color_ready at a clk rising edge.
- r_duty  input  PWM_BITS  red duty; on-ticks per period.
- g_duty  input  PWM_BITS  green duty.
- b_duty  input  PWM_BITS  blue duty.
- RGB_R  output  1  red LED, active low (0 = lit).
- RGB_G  output  1  green LED, active low.
- RGB_B  output  1  blue LED, active low.
- period_start  output  1  one-cycle pulse when the PWM counter wraps to 0.

Behaviour:
- Reset (async, rst=1):
  - pre_cnt = 0, pwm_cnt = 0.
  - Active duties = 0, pending buffer empty.
  - RGB_R/G/B = 1 (all off), period_start = 0.
  - color_ready = 1, but no transfer is accepted while rst is high.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 and wraps.
  - tick = (pre_cnt == PRESCALE-1).
  - With PRESCALE=1, tick is high every cycle.
- PWM counter:
  - On tick, pwm_cnt increments; it wraps from 2^PWM_BITS-1 to 0.
  - boundary = tick && pwm_cnt == 2^PWM_BITS-1.
- Handshake:
  - color_ready = ~pending_full, combinational from the register.
  - On transfer, all three duties are latched into the pending buffer and pending_full is set.
  - Inputs are ignored when no transfer occurs.
  - Upstream must hold data stable while valid && !ready.
- Boundary load:
  - On a boundary edge with pending_full=1: active duties <= pending, pending_full <= 0, and color_ready rises the following cycle.
  - On a boundary edge with pending_full=0: active duties are unchanged.
- Simultaneous transfer and boundary:
  - A transfer can only happen while pending is empty.
  - The data goes to pending and becomes active at the NEXT boundary. There is no bypass path.
- period_start: registered; equals 1 for exactly the one cycle after each boundary edge, i.e. the first cycle with pwm_cnt = 0.
- Output compare (registered, 1-cycle latency):
  - Each clk, RGB_x <= ~(pwm_cnt < active_x), using current-cycle values.
  - duty 0 gives a pin that is never lit.
  - duty 2^PWM_BITS-1 gives a pin lit for 255/256 of the period. Full-on is not reachable by design.
  - A new duty first appears on the pins one clk after period_start.
- Mid-operation reset: all state returns to reset values immediately; any pending data is discarded.
- Width rule: the compare is unsigned PWM_BITS-wide; no arithmetic overflow beyond the counter wrap.

Test Plan:
- Reset check: PRESCALE=1; assert rst mid-period with pending full → pins=1 and period_start=0 immediately; color_ready=1; after release, pwm_cnt restarts at 0 and pins stay off (duty 0).
- Duty accuracy: PRESCALE=1; send R=64, G=128, B=0, then run two full periods → per 256-cycle period, RGB_R low for exactly 64 cycles, RGB_G low for 128, RGB_B never low; period_start pulses every 256 cycles.
- Boundary alignment: send R=255 mid-period → old duty holds until the boundary; RGB_R goes low one clk after period_start and stays low 255 cycles per period.
- Backpressure: two back-to-back transfers within one period → second is stalled (color_ready=0) until the cycle after the boundary edge, then accepted; its values take effect at the following boundary.
- Simultaneous event: valid asserted on the exact boundary cycle with pending empty → accepted into pending, not applied until the next boundary 256 cycles later.
- Prescaler: PRESCALE=47 default; duty R=1 → RGB_R low for 47 clk per 12032-clk period; period_start spacing = 12032 clk.
